// File: rtl/shift_datapath.sv
// Two chained WIDTH-bit operand registers with parallel load and a serial right shift.
// One-cycle load/shift; Done is registered one cycle after a burst of exactly SHIFTS shifts.
module shift_datapath #(
  parameter int WIDTH  = 8,
  parameter int SHIFTS = WIDTH
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Ld_A,
  input  logic                        Ld_B,
  input  logic                        Shift_En,
  input  logic [WIDTH-1:0]            Din,
  input  logic                        Shift_In,
  input  logic                        Clr_Err,
  output logic [WIDTH-1:0]            A,
  output logic [WIDTH-1:0]            B,
  output logic                        A_out,
  output logic                        B_out,
  output logic [$clog2(SHIFTS+1)-1:0] Shift_Count,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Err
);

  localparam int CW = $clog2(SHIFTS + 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(SHIFTS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic       overrun;
  logic       load_any;
  logic [WIDTH-1:0] a_shifted;
  logic [WIDTH-1:0] b_shifted;

  assign load_any  = Ld_A | Ld_B;
  assign a_shifted = {Shift_In, A[WIDTH-1:1]};
  assign b_shifted = {A[0], B[WIDTH-1:1]};

  assign A_out = A[0];
  assign B_out = B[0];
  assign Busy  = (state == SHIFT);

  // Error sets are written after the clear so a same-cycle error keeps Err high.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      A           <= '0;
      B           <= '0;
      Shift_Count <= '0;
      Done        <= 1'b0;
      Err         <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Clr_Err) Err <= 1'b0;

      case (state)
        IDLE: begin
          if (Ld_A) A <= Din;
          if (Ld_B) B <= Din;
          if (Shift_En && load_any) begin
            Err <= 1'b1;
          end else if (Shift_En) begin
            A           <= a_shifted;
            B           <= b_shifted;
            Shift_Count <= CW'(1);
            overrun     <= 1'b0;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          if (load_any) Err <= 1'b1;
          if (Shift_En) begin
            if (Shift_Count == MAX_COUNT) begin
              Err     <= 1'b1;
              overrun <= 1'b1;
            end else begin
              A           <= a_shifted;
              B           <= b_shifted;
              Shift_Count <= Shift_Count + 1'b1;
            end
          end else begin
            state <= IDLE;
            // An overrun burst already flagged Err; it must not also report Done.
            if (Shift_Count == MAX_COUNT) begin
              if (!overrun) Done <= 1'b1;
            end else begin
              Err <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_datapath.md
Name: shift_datapath

Overview:
- Responder side of the shift/load strobe interface driven by the serial-processor control FSM.
- Holds the two WIDTH-bit operand registers A and B. Loads them on Ld_A/Ld_B and performs one chained right shift per Shift_En cycle.
- Counts each contiguous Shift_En burst and reports completion (Done) or a protocol violation (Err) back to top level.

Parameters:
- WIDTH, 8: operand register width in bits.
- SHIFTS, WIDTH: required number of Shift_En cycles per operation burst.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Ld_A  input  1  load A from Din this cycle.
- Ld_B  input  1  load B from Din this cycle.
- Shift_En  input  1  perform one chained shift this cycle.
- Din  input  WIDTH  parallel load data.
- Shift_In  input  1  serial bit entering A[WIDTH-1] on shift.
- Clr_Err  input  1  synchronous clear of sticky Err.
- A  output  WIDTH  register A contents.
- B  output  WIDTH  register B contents.
- A_out  output  1  A[0], combinational.
- B_out  output  1  B[0], combinational.
- Shift_Count  output  $clog2(SHIFTS+1)  shifts taken in current/last burst.
- Busy  output  1  high while in SHIFT state.
- Done  output  1  one-cycle pulse: burst of exactly SHIFTS completed.
- Err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, Reset_n=0): A=0, B=0, Shift_Count=0, Busy=0, Done=0, Err=0, state=IDLE. Reset mid-burst aborts with no Done.
- Shift operation (one cycle):
  - A <= {Shift_In, A[WIDTH-1:1]}.
  - B <= {A[0], B[WIDTH-1:1]}.
  - The old B[0] is discarded.
- Loads: Ld_A sets A<=Din; Ld_B sets B<=Din; both high loads both. Visible the cycle after the edge.
- FSM states are IDLE and SHIFT; Done is registered.
- IDLE:
  - Shift_En=1 with no load: shift, Shift_Count<=1, go to SHIFT.
  - Shift_En=1 together with Ld_A or Ld_B: the load wins, the shift is suppressed, Err<=1, stay IDLE.
  - Loads alone are legal in IDLE.
- SHIFT (Busy=1):
  - Shift_En=1 and Shift_Count<SHIFTS: shift, count+1.
  - Shift_En=1 and Shift_Count==SHIFTS: overrun. No shift, Err<=1, count holds at SHIFTS, stay SHIFT.
  - Shift_En=0: go to IDLE. Done<=1 for exactly one cycle iff Shift_Count==SHIFTS; otherwise Err<=1 (underrun). Shift_Count holds its final value in IDLE.
  - Ld_A or Ld_B in SHIFT: load ignored, Err<=1. The shift still occurs if Shift_En=1.
- Err:
  - Sticky; cleared only by Clr_Err=1 or reset.
  - A new error in the same cycle as Clr_Err=1 wins, so Err stays 1.
- Done and Busy are never high in the same cycle.
- Timing and overflow:
  - Latency from the first Shift_En to Done is SHIFTS+1 cycles.
  - Back-to-back bursts separated by one idle cycle are legal.
  - Shift_Count never wraps.

Test Plan:
- Load/shift: Ld_A with Din=0x5A, then Ld_B with Din=0xC3; 8 Shift_En cycles, Shift_In=0 -> A=0x00, B=0x5A. Done pulses once, 1 cycle after the last shift; Err=0; Shift_Count=8.
- Serial fill: A=0x00, B=0xFF, Shift_In=1 for 8 shifts -> A=0xFF, B=0x00. A_out and B_out track bit 0 each cycle.
- Underrun: 5-cycle Shift_En burst -> Err=1, Done never asserted, Shift_Count=5. Clr_Err pulse -> Err=0.
- Overrun: 10-cycle burst from A=0x81, B=0x00, Shift_In=0 -> state freezes after the 8th shift (A=0x00, B=0x81). Err=1, Shift_Count=8, no Done at burst end.
- Protocol violations:
  - Ld_A with Din=0xAA during cycle 3 of a burst -> A is not loaded, shifting continues, Err=1.
  - In IDLE, Ld_B and Shift_En together with Din=0x33 -> B=0x33, no shift, Err=1, Busy stays 0.
- Async reset: drive Reset_n low mid-cycle during cycle 4 of a burst -> all outputs 0 immediately with no clock edge; no Done after release.
